load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
- REQ-001 Parameter: TIMEOUT, default 255, maximum WAIT-state cycles before a load response is abandoned.
- REQ-002 clk  in  1  single clock; all state changes on the rising edge.
- REQ-003 rst  in  1  synchronous, active-high reset.
- REQ-004 req_valid  in  1  memory-stage access request; held stable while stall=1.
- REQ-005 req_write  in  1  1=store, 0=load.
- REQ-006 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ-007 req_addr  in  `XLEN  byte address.
- REQ-008 req_wdata  in  `XLEN  store data, right-aligned.
- REQ-009 read_data  out  `XLEN  formatted load result to the write-back stage mux (memory-result source).
- REQ-010 stall  out  1  freeze the pipeline while the access is incomplete.
- REQ-011 bus_err  out  1  one-cycle pulse: the load timed out.
- REQ-012 bus_req_valid / bus_req_ready  out / in  1 / 1  bus request handshake.
- REQ-013 bus_addr  out  `XLEN  word-aligned address (bits [1:0]=00).
- REQ-014 bus_we, bus_wstrb, bus_wdata  out  1, `XLEN/8, `XLEN  write enable, byte strobes, lane-placed data.
- REQ-015 bus_rsp_valid, bus_rdata  in  1, `XLEN  read response, one cycle, only after an accepted read.

Function
- REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
- REQ-017 IDLE: req_valid=1 and access legal -> latch addr/wdata/funct3/write, go to REQ.
- REQ-018 REQ: bus_req_valid=1 with latched fields; on bus_req_ready: store -> DONE, load -> WAIT.
- REQ-019 WAIT: on bus_rsp_valid, register formatted data into read_data, go to DONE; a response arriving in the same cycle as the timeout SHALL win.
- REQ-020 WAIT: the cycle counter SHALL reach TIMEOUT without a response -> bus_err=1 for one cycle, read_data=0, go to DONE.
- REQ-021 DONE: unconditionally -> IDLE; read_data holds its value until the next load completes.
- REQ-022 stall = req_valid AND state!=DONE (combinational); a load's minimum latency SHALL be 3 cycles of stall, a store's 2.
- REQ-023 Load formatting: select the byte/half lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass through.
- REQ-024 Store: SB strobe 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; data replicated across lanes.
- REQ-025 Misaligned access: H with addr[0]=1, or W with addr[1:0]!=00.
- REQ-026 A response seen in IDLE, REQ or DONE SHALL be ignored.

Reset
- REQ-027 rst SHALL force state=IDLE, read_data=0, bus_err=0, bus_req_valid=0, counter=0.
- REQ-028 rst mid-transaction SHALL abandon the access; no bus_req_valid is raised in the cycle after reset.

Configuration
- REQ-029 Macro MISALIGN_TRAP_EN: when defined, output port misaligned (1 bit) SHALL exist; a misaligned request asserts misaligned combinationally, issues no bus request, stall=0.
- REQ-030 Without MISALIGN_TRAP_EN: the port SHALL be absent and misaligned accesses SHALL proceed with the address aligned down (lane = aligned offset).

Structure
- REQ-031 FSM state encoding, funct3 width codes and TIMEOUT default SHALL live in the shared constants header alongside `XLEN.
- REQ-032 Lane extract/extend and strobe/replicate logic SHALL be one combinational sub-module, lsu_formatter.

Verification
- REQ-033 LB addr 0x1003, bus_rdata 0x80FF_0000, ready immediate -> read_data 0xFFFF_FF80, stall high 3 cycles.
- REQ-034 SH addr 0x2002, wdata 0x0000_BEEF -> bus_wstrb 1100, bus_wdata 0xBEEF_BEEF, bus_addr 0x2000.
- REQ-035 LHU addr 0x0, bus_req_ready delayed 4 cycles, bus_rdata 0x1234_F00D -> read_data 0x0000_F00D.
- REQ-036 LW with no response, TIMEOUT=8 -> bus_err pulse after 8 WAIT cycles, read_data 0, then IDLE.
- REQ-037 rst asserted during WAIT, late bus_rsp_valid -> read_data stays 0, state IDLE.
- REQ-038 MISALIGN_TRAP_EN defined, LW addr 0x3 -> misaligned=1, bus_req_valid never 1, stall=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// -----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared constants for the load/store unit: data width (`XLEN), FSM state
// encoding, RV32I load/store width codes, default load timeout and the
// misalignment predicate used by the request decoder.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package load_store_unit_pkg;

    localparam int XLEN            = `XLEN;
    localparam int NBYTES          = XLEN / 8;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords must sit on an even byte, words on a word boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic r;
        r = 1'b0;
        case (funct3)
            F3_H, F3_HU: r = off[0];
            F3_W:        r = (off != 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_store_unit_formatter.sv
// -----------------------------------------------------------------------------
// lsu_formatter
// Purely combinational lane logic for the load/store unit.
//   funct3_i  : RV32I width code of the access
//   offset_i  : byte offset within the word (addr[1:0])
//   wdata_i   : right-aligned store data
//   rdata_i   : raw word returned by the bus
//   wstrb_o   : byte strobes for a store
//   wdata_o   : store data replicated across all lanes
//   rdata_o   : extracted and sign/zero-extended load result
// Misaligned offsets are aligned down to the natural boundary of the access,
// so a halfword at offset 1 uses lane 0 and a word always uses lane 0.
// -----------------------------------------------------------------------------
module lsu_formatter
    import load_store_unit_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [NBYTES-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o
);

    logic [1:0]      lane_off;
    logic [XLEN-1:0] lane_data;

    // funct3[1:0] carries the size for both signed and unsigned codes.
    always_comb begin
        lane_off = 2'b00;
        case (funct3_i[1:0])
            2'b00:   lane_off = offset_i;
            2'b01:   lane_off = {offset_i[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    end

    assign lane_data = rdata_i >> {lane_off, 3'b000};

    always_comb begin
        wstrb_o = '0;
        wdata_o = wdata_i;
        rdata_o = '0;
        case (funct3_i)
            F3_B: begin
                rdata_o = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
                wstrb_o = NBYTES'(1) << lane_off;
                wdata_o = {NBYTES{wdata_i[7:0]}};
            end
            F3_H: begin
                rdata_o = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
                wstrb_o = NBYTES'(3) << lane_off;
                wdata_o = {(NBYTES/2){wdata_i[15:0]}};
            end
            F3_W: begin
                rdata_o = lane_data;
                wstrb_o = '1;
                wdata_o = wdata_i;
            end
            F3_BU: rdata_o = {{(XLEN-8){1'b0}}, lane_data[7:0]};
            F3_HU: rdata_o = {{(XLEN-16){1'b0}}, lane_data[15:0]};
            default: begin
                rdata_o = '0;
                wstrb_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory-stage load/store engine between the pipeline and a valid/ready bus.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : pipeline access request (held while stall=1)
//   read_data           : registered, formatted load result
//   stall               : freeze the pipeline until the access completes
//   bus_err             : one-cycle pulse when a load response times out
//   bus_req_valid/ready : bus request handshake
//   bus_addr/we/wstrb/wdata : word-aligned request fields
//   bus_rsp_valid/rdata : single-cycle read response
//   misaligned          : only with MISALIGN_TRAP_EN; flags and blocks a
//                         misaligned request instead of aligning it down
// Parameter TIMEOUT: WAIT cycles allowed before a load is abandoned.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no access in flight; accept a legal request and latch it
// REQ   | bus_req_valid asserted until bus_req_ready
// WAIT  | load accepted, counting down for bus_rsp_valid
// DONE  | access complete, stall released for one cycle
// -----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [XLEN-1:0]   read_data,
    output logic              stall,
    output logic              bus_err,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [XLEN-1:0]   bus_addr,
    output logic              bus_we,
    output logic [NBYTES-1:0] bus_wstrb,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misaligned
`endif
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   read_data_q, read_data_d;
    logic              bus_err_q, bus_err_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              write_q, write_d;

    logic              trap;
    logic [NBYTES-1:0] fmt_wstrb;
    logic [XLEN-1:0]   fmt_wdata;
    logic [XLEN-1:0]   fmt_rdata;

`ifdef MISALIGN_TRAP_EN
    assign trap       = req_valid && is_misaligned(req_funct3, req_addr[1:0]);
    assign misaligned = trap;
`else
    assign trap = 1'b0;
`endif

    lsu_formatter u_formatter (
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus_rdata),
        .wstrb_o  (fmt_wstrb),
        .wdata_o  (fmt_wdata),
        .rdata_o  (fmt_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            write_q     <= write_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        read_data_d   = read_data_q;
        bus_err_d     = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        funct3_d      = funct3_q;
        write_d       = write_q;
        bus_req_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !trap) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    write_d  = req_write;
                    state_d  = REQ;
                end
            end
            REQ: begin
                bus_req_valid = 1'b1;
                if (bus_req_ready) begin
                    if (write_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Response is checked first so it wins over a same-cycle timeout.
                if (bus_rsp_valid) begin
                    read_data_d = fmt_rdata;
                    state_d     = DONE;
                end else if (cnt_q == '0) begin
                    read_data_d = '0;
                    bus_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall     = req_valid && (state_q != DONE) && !trap;
    assign read_data = read_data_q;
    assign bus_err   = bus_err_q;
    assign bus_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign bus_we    = write_q;
    assign bus_wstrb = write_q ? fmt_wstrb : '0;
    assign bus_wdata = fmt_wdata;

endmodule
